mcm_tap_scheduler: RTL and testbench



---
 rtl/mcm_tap_scheduler.sv | 124 ++++++++++++
 tb/tb_mcm_tap_scheduler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mcm_tap_scheduler.sv
// Tap scheduler for a shared 4-output MCM (-2,-3,3,11).
// Walks four reference samples through the MCM, accumulates, rounds and clips.
module mcm_tap_scheduler #(
    parameter int BIT_DEPTH = 8,
    parameter int ACC_W     = 18,
    parameter int SHIFT     = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*BIT_DEPTH-1:0] in_samples,
    input  logic [7:0]             in_sel,
    input  logic [3:0]             in_neg,
    output logic [BIT_DEPTH-1:0]   mcm_x,
    input  logic [15:0]            mcm_y1,
    input  logic [15:0]            mcm_y2,
    input  logic [15:0]            mcm_y3,
    input  logic [15:0]            mcm_y4,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BIT_DEPTH-1:0]   out_sample,
    output logic                   busy
);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    localparam logic signed [ACC_W-1:0] RND  = ACC_W'(1 << (SHIFT - 1));
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 << BIT_DEPTH) - 1);

    state_t                  state, state_nxt;
    logic [1:0]              cnt;
    logic signed [ACC_W-1:0] acc;
    logic [BIT_DEPTH-1:0]    smp [4];
    logic [1:0]              tsel [4];
    logic [3:0]              neg;

    logic                    accept;
    logic signed [15:0]      y_sel;
    logic signed [ACC_W-1:0] ext, p, sum, rnd, shifted;
    logic [BIT_DEPTH-1:0]    clip_val;

    // Handshake, MCM drive and product select for the current tap
    always_comb begin
        in_ready = (state == IDLE) || (state == OUT && out_ready);
        accept   = in_valid && in_ready;
        busy     = (state != IDLE);
        mcm_x    = (state == MAC) ? smp[cnt] : '0;
        y_sel    = mcm_y1;
        unique case (tsel[cnt])
            2'd0: y_sel = mcm_y1;
            2'd1: y_sel = mcm_y2;
            2'd2: y_sel = mcm_y3;
            2'd3: y_sel = mcm_y4;
        endcase
        ext      = {{(ACC_W-16){y_sel[15]}}, y_sel};
        p        = neg[cnt] ? -ext : ext;
        sum      = acc + p;
        rnd      = sum + RND;
        shifted  = rnd >>> SHIFT;
        if (shifted < 0)
            clip_val = '0;
        else if (shifted > MAXV)
            clip_val = MAXV[BIT_DEPTH-1:0];
        else
            clip_val = shifted[BIT_DEPTH-1:0];
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = MAC;
            MAC:  if (cnt == 2'd3) state_nxt = OUT;
            OUT: begin
                if (out_ready) state_nxt = accept ? MAC : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Group latch, accumulation and result register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            acc        <= '0;
            out_valid  <= 1'b0;
            out_sample <= '0;
            neg        <= '0;
            for (int i = 0; i < 4; i++) begin
                smp[i]  <= '0;
                tsel[i] <= '0;
            end
        end else begin
            if (state == OUT && out_ready)
                out_valid <= 1'b0;
            if (accept) begin
                acc <= '0;
                cnt <= '0;
                neg <= in_neg;
                for (int i = 0; i < 4; i++) begin
                    smp[i]  <= in_samples[i*BIT_DEPTH +: BIT_DEPTH];
                    tsel[i] <= in_sel[2*i +: 2];
                end
            end
            if (state == MAC) begin
                if (cnt != 2'd3) begin
                    acc <= sum;
                    cnt <= cnt + 2'd1;
                end else begin
                    out_sample <= clip_val;
                    out_valid  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mcm_tap_scheduler.sv
// Bench for mcm_tap_scheduler: two instances (SHIFT=6 and SHIFT=2) on shared
// stimulus, checked every cycle against a cycle-level behavioural model.
module tb_mcm_tap_scheduler;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready;
    logic [31:0] in_samples;
    logic [7:0]  in_sel;
    logic [3:0]  in_neg;

    logic        ir_a, ov_a, busy_a, ir_b, ov_b, busy_b;
    logic [7:0]  mx_a, os_a, mx_b, os_b;
    logic [15:0] ya1, ya2, ya3, ya4, yb1, yb2, yb3, yb4;

    int checks = 0;
    int failures = 0;

    bit m_mac, m_out;
    int m_k;
    int m_smp [4];
    int m_os6, m_os2, m_res6, m_res2;

    always #5 clk = ~clk;

    // Behavioural MCM: plain constant products of the driven sample
    assign ya1 = 16'(-2 * int'(mx_a));
    assign ya2 = 16'(-3 * int'(mx_a));
    assign ya3 = 16'(3 * int'(mx_a));
    assign ya4 = 16'(11 * int'(mx_a));
    assign yb1 = 16'(-2 * int'(mx_b));
    assign yb2 = 16'(-3 * int'(mx_b));
    assign yb3 = 16'(3 * int'(mx_b));
    assign yb4 = 16'(11 * int'(mx_b));

    mcm_tap_scheduler #(.BIT_DEPTH(8), .ACC_W(18), .SHIFT(6)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_a),
        .in_samples(in_samples), .in_sel(in_sel), .in_neg(in_neg),
        .mcm_x(mx_a), .mcm_y1(ya1), .mcm_y2(ya2), .mcm_y3(ya3), .mcm_y4(ya4),
        .out_valid(ov_a), .out_ready(out_ready), .out_sample(os_a),
        .busy(busy_a)
    );

    mcm_tap_scheduler #(.BIT_DEPTH(8), .ACC_W(18), .SHIFT(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_b),
        .in_samples(in_samples), .in_sel(in_sel), .in_neg(in_neg),
        .mcm_x(mx_b), .mcm_y1(yb1), .mcm_y2(yb2), .mcm_y3(yb3), .mcm_y4(yb4),
        .out_valid(ov_b), .out_ready(out_ready), .out_sample(os_b),
        .busy(busy_b)
    );

    function automatic int ref_result(logic [31:0] s, logic [7:0] sl,
                                      logic [3:0] ng, int sh);
        int coef [4];
        int sum, p, r;
        coef = '{-2, -3, 3, 11};
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            p = coef[sl[2*i +: 2]] * int'(s[8*i +: 8]);
            if (ng[i]) p = -p;
            sum += p;
        end
        r = (sum + (1 << (sh - 1))) >>> sh;
        if (r < 0) r = 0;
        if (r > 255) r = 255;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare DUT against the model, then advance the model over one edge
    task automatic step();
        bit acc_now;
        #1;
        chk("in_ready_a", 32'(ir_a), 32'(!m_mac && (!m_out || out_ready)));
        chk("in_ready_b", 32'(ir_b), 32'(!m_mac && (!m_out || out_ready)));
        chk("out_valid_a", 32'(ov_a), 32'(m_out));
        chk("out_valid_b", 32'(ov_b), 32'(m_out));
        chk("busy_a", 32'(busy_a), 32'(m_mac || m_out));
        chk("busy_b", 32'(busy_b), 32'(m_mac || m_out));
        chk("mcm_x_a", 32'(mx_a), m_mac ? m_smp[m_k] : 0);
        chk("mcm_x_b", 32'(mx_b), m_mac ? m_smp[m_k] : 0);
        chk("out_sample_a", 32'(os_a), m_os6);
        chk("out_sample_b", 32'(os_b), m_os2);
        @(posedge clk);
        if (!rst_n) begin
            m_mac = 0; m_out = 0; m_k = 0; m_os6 = 0; m_os2 = 0;
        end else if (m_mac) begin
            if (m_k == 3) begin
                m_mac = 0; m_out = 1; m_os6 = m_res6; m_os2 = m_res2;
            end else begin
                m_k++;
            end
        end else begin
            acc_now = in_valid && (!m_out || out_ready);
            if (m_out && out_ready) m_out = 0;
            if (acc_now) begin
                m_mac = 1; m_k = 0;
                for (int i = 0; i < 4; i++) m_smp[i] = int'(in_samples[8*i +: 8]);
                m_res6 = ref_result(in_samples, in_sel, in_neg, 6);
                m_res2 = ref_result(in_samples, in_sel, in_neg, 2);
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_out(input string nm);
        int n;
        n = 0;
        while (!m_out && n < 12) begin
            step();
            n++;
        end
        chk({nm, "_ov"}, 32'(ov_a), 32'd1);
    endtask

    // Directed group from idle with literal expected results
    task automatic run_group(input string nm, input logic [31:0] s,
                             input logic [7:0] sl, input logic [3:0] ng,
                             input int lit6, input int lit2);
        in_samples = s; in_sel = sl; in_neg = ng;
        in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        wait_out(nm);
        chk({nm, "_s6"}, 32'(os_a), lit6);
        chk({nm, "_s2"}, 32'(os_b), lit2);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        m_mac = 0; m_out = 0; m_k = 0; m_os6 = 0; m_os2 = 0;
        m_res6 = 0; m_res2 = 0;
        for (int i = 0; i < 4; i++) m_smp[i] = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_samples = '0; in_sel = '0; in_neg = '0;
        @(negedge clk);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", 32'(ir_a), 32'd1);
        chk("rst_busy", 32'(busy_a), 32'd0);

        run_group("basic", {8'd40, 8'd30, 8'd20, 8'd10}, 8'hFF, 4'b0000, 17, 255);
        run_group("mixed", {8'd100, 8'd100, 8'd100, 8'd100},
                  {2'd1, 2'd3, 2'd3, 2'd0}, 4'b1000, 36, 255);
        run_group("lowclip", 32'hFFFF_FFFF, 8'h00, 4'b0000, 0, 0);
        run_group("hiclip", 32'hFFFF_FFFF, 8'hFF, 4'b0000, 175, 255);

        // Reset during the third MAC cycle abandons the group
        in_samples = 32'h0A0B0C0D; in_sel = 8'hFF; in_neg = 4'b0000;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("rst_mid_ov", 32'(ov_a), 32'd0);

        // Backpressure then back-to-back handshake + accept
        in_samples = {8'd4, 8'd3, 8'd2, 8'd1}; in_sel = 8'hFF; in_neg = 4'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_out("bp");
        for (int i = 0; i < 7; i++) step();
        chk("bp_hold", 32'(os_a), 32'd2);
        in_samples = {8'd40, 8'd30, 8'd20, 8'd10};
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_busy", 32'(busy_a), 32'd1);
        wait_out("b2b");
        chk("b2b_s6", 32'(os_a), 32'd17);
        out_ready = 1'b1;
        step();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst_n      = ($urandom_range(0, 79) != 0);
            in_valid   = $urandom_range(0, 1) == 1;
            out_ready  = $urandom_range(0, 2) != 0;
            in_samples = $urandom;
            in_sel     = 8'($urandom);
            in_neg     = 4'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
